ro_scan_meter: RTL and testbench
================================

RO_SCAN_METER -- requirements
Module: ro_scan_meter

Interface
REQ-001 Parameter N_CH, default 4: number of ring-oscillator channels (2..16).
REQ-002 Parameter CNT_W, default 16: edge-counter and result width.
REQ-003 Parameter WIN_W, default 16: measurement-window length field width.
REQ-004 Parameter AVG_MAX, default 3: maximum log2 of averaged windows.
REQ-005 Parameter SETTLE_CYC, default 8: clk cycles between oscillator enable and counting.
REQ-006 clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  block enable; low aborts any operation.
REQ-009 start  in  1  one-cycle pulse, begins a scan when idle.
REQ-010 cont  in  1  1 = continuous scan, 0 = single pass.
REQ-011 ch_mask  in  N_CH  channels included in the scan.
REQ-012 win_len  in  WIN_W  window length in clk cycles.
REQ-013 avg_log2  in  3  windows averaged = 2^avg_log2.
REQ-014 ro_in  in  N_CH  asynchronous oscillator outputs.
REQ-015 ro_en  out  N_CH  one-hot oscillator enable.
REQ-016 busy  out  1  high outside IDLE.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  consumer accepts result.
REQ-019 res_ch  out  $clog2(N_CH)  channel of result.
REQ-020 res_data  out  CNT_W  averaged edge count.
REQ-021 res_sat  out  1  at least one averaged window saturated.

Function
REQ-022 start, cont, ch_mask, win_len and avg_log2 SHALL be sampled only when start is accepted in IDLE; later changes have no effect until the next scan.
REQ-023 start SHALL be ignored when en=0, ch_mask=0 or busy=1.
REQ-024 States: IDLE, SETTLE, MEASURE, OUTPUT; each state change SHALL take exactly one clk.
REQ-025 IDLE->SETTLE on accepted start; the selected channel is the lowest set bit of ch_mask.
REQ-026 In SETTLE, MEASURE and OUTPUT, ro_en SHALL be one-hot on the current channel; in IDLE, ro_en SHALL be 0.
REQ-027 SETTLE SHALL last SETTLE_CYC cycles, then go to MEASURE with counter and accumulator cleared.
REQ-028 ro_in SHALL pass through a 2-flop synchronizer; each synchronized rising edge SHALL increment the window counter, which SHALL saturate at 2^CNT_W-1.
REQ-029 A window SHALL last win_len cycles; win_len=0 SHALL be treated as 1.
REQ-030 At window end, count SHALL be added into a CNT_W+AVG_MAX-bit accumulator; counting SHALL restart the next cycle with no dead cycle.
REQ-031 avg_log2 above AVG_MAX SHALL be clamped to AVG_MAX.
REQ-032 After 2^avg_log2 windows: res_data = accumulator >> avg_log2 (truncating); res_sat = OR of per-window saturation; state goes to OUTPUT with res_valid=1.
REQ-033 In OUTPUT, res_valid, res_ch, res_data and res_sat SHALL hold stable until res_valid&&res_ready.
REQ-034 On handshake, next channel = next set mask bit above current, wrapping to the lowest set bit.
REQ-035 On wrap with cont=0, the next state SHALL be IDLE; otherwise the next state SHALL be SETTLE on the next channel.
REQ-036 A mask with a single set bit and cont=1 SHALL re-measure the same channel, including SETTLE.
REQ-037 en=0 in any state SHALL force IDLE next cycle: ro_en=0, res_valid=0, and any pending result is discarded.
REQ-038 Result latency = SETTLE_CYC + 2^avg_log2 × win_len + 1 cycles from entering SETTLE to res_valid; the synchronizer delay may shift edge attribution by 2 cycles.

Reset
REQ-039 On rst: state IDLE, ro_en=0, busy=0, res_valid=0, res_ch=0, res_data=0, res_sat=0, and all counters, accumulators and synchronizers cleared.
REQ-040 rst SHALL take priority over en and start in the same cycle.

Structure
REQ-041 Package ro_meter_pkg SHALL hold the state encoding and the default parameter constants.
REQ-042 Sub-module ro_edge_counter SHALL contain the synchronizer, edge detector and saturating counter for the muxed channel.
REQ-043 Channel mux, window timer, accumulator and FSM SHALL reside in ro_scan_meter.

Verification
REQ-044 N_CH=4, mask=4'b0101, cont=0, win_len=100, avg_log2=0, ro_in[0] period 10 clk, ro_in[2] period 4 clk -> results ch0≈10 and ch2≈25 in order, then IDLE with busy=0.
REQ-045 avg_log2=2, win_len=50, period 5 -> res_data=10±1, exactly one result after 4 windows.
REQ-046 CNT_W=4, win_len=100, period 2 -> res_data=15, res_sat=1.
REQ-047 res_ready held low 20 cycles -> outputs stable for all 20 cycles, no new measurement is accepted, and the scan continues after the handshake.
REQ-048 en dropped mid-MEASURE -> next cycle IDLE, ro_en=0, res_valid=0; start with mask=0 -> busy stays 0.
REQ-049 cont=1, mask=4'b1000 -> repeated ch3 results with a SETTLE between each; rst mid-scan -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ro_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_meter_pkg
// Description : Shared state encoding, default parameters and mask-scanning
//               helpers for the ring-oscillator scan meter.
// Revision    : 1.0 - initial release
// ============================================================================
package ro_meter_pkg;

    localparam int C_N_CH       = 4;
    localparam int C_CNT_W      = 16;
    localparam int C_WIN_W      = 16;
    localparam int C_AVG_MAX    = 3;
    localparam int C_SETTLE_CYC = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // Masks are zero-extended to 16 bits so one helper serves every N_CH.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Returns {wrapped, index}: next set bit above cur, else the lowest set bit.
    function automatic logic [4:0] next_set(input logic [15:0] mask, input logic [3:0] cur);
        logic [4:0] res;
        res = {1'b1, lowest_set(mask)};
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) res = {1'b0, 4'(i)};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : ro_edge_counter
// Description : 2-flop synchronizer, rising-edge detector and saturating
//               window counter for the currently selected oscillator.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ro,
    output logic [CNT_W-1:0] count_nxt,
    output logic             sat_nxt
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic             w_rise;
    logic             w_full;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_full = &r_count;

    // Next values include this cycle's edge so a window end loses nothing.
    always_comb begin
        count_nxt = r_count;
        if (w_rise && !w_full) count_nxt = r_count + CNT_W'(1);
        sat_nxt = r_sat | (w_rise & w_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_sync1 <= ro;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (clr) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else begin
                r_count <= count_nxt;
                r_sat   <= sat_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ro_scan_meter.sv
`default_nettype none
// ============================================================================
// Module      : ro_scan_meter
// Description : Scans masked ring oscillators one at a time, averaging
//               2^avg_log2 edge-count windows per channel into one result.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_scan_meter
    import ro_meter_pkg::*;
#(
    parameter int N_CH       = C_N_CH,
    parameter int CNT_W      = C_CNT_W,
    parameter int WIN_W      = C_WIN_W,
    parameter int AVG_MAX    = C_AVG_MAX,
    parameter int SETTLE_CYC = C_SETTLE_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    cont,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [2:0]              avg_log2,
    input  logic [N_CH-1:0]         ro_in,
    output logic [N_CH-1:0]         ro_en,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]        res_data,
    output logic                    res_sat
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int ACC_W  = CNT_W + AVG_MAX;
    localparam int WIDX_W = AVG_MAX + 1;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    state_t             r_state;
    logic               r_cont;
    logic [N_CH-1:0]    r_mask;
    logic [WIN_W-1:0]   r_win_len;
    logic [2:0]         r_avg;
    logic [CH_W-1:0]    r_ch;
    logic [SET_W-1:0]   r_settle;
    logic [WIN_W-1:0]   r_timer;
    logic [WIDX_W-1:0]  r_win_idx;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_sat;

    logic [CH_W-1:0]    w_start_ch;
    logic [4:0]         w_next;
    logic [CH_W-1:0]    w_next_ch;
    logic               w_wrap;
    logic [WIN_W-1:0]   w_win_len_eff;
    logic [2:0]         w_avg_clamp;
    logic               w_win_end;
    logic               w_last_win;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_cnt_clr;
    logic               w_ro_sel;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_sat_nxt;
    logic [N_CH-1:0]    w_onehot_start;
    logic [N_CH-1:0]    w_onehot_next;

    assign w_start_ch     = CH_W'(lowest_set(16'(ch_mask)));
    assign w_next         = next_set(16'(r_mask), 4'(r_ch));
    assign w_next_ch      = CH_W'(w_next[3:0]);
    assign w_wrap         = w_next[4];
    assign w_onehot_start = {{(N_CH-1){1'b0}}, 1'b1} << w_start_ch;
    assign w_onehot_next  = {{(N_CH-1){1'b0}}, 1'b1} << w_next_ch;

    assign w_win_len_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_avg_clamp    = (int'(avg_log2) > AVG_MAX) ? 3'(AVG_MAX) : avg_log2;

    assign w_win_end      = (r_timer == r_win_len - WIN_W'(1));
    assign w_last_win     = (r_win_idx == WIDX_W'((1 << r_avg) - 1));
    assign w_acc_sum      = r_acc + ACC_W'(w_count_nxt);

    // Counter is held clear outside MEASURE and restarts right after each window.
    assign w_cnt_clr      = (r_state != S_MEASURE) || w_win_end;
    assign w_ro_sel       = ro_in[r_ch];

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_cnt_clr),
        .ro        (w_ro_sel),
        .count_nxt (w_count_nxt),
        .sat_nxt   (w_sat_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cont    <= 1'b0;
            r_mask    <= '0;
            r_win_len <= '0;
            r_avg     <= '0;
            r_ch      <= '0;
            r_settle  <= '0;
            r_timer   <= '0;
            r_win_idx <= '0;
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
            ro_en     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else if (!en) begin
            r_state   <= S_IDLE;
            ro_en     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        r_cont    <= cont;
                        r_mask    <= ch_mask;
                        r_win_len <= w_win_len_eff;
                        r_avg     <= w_avg_clamp;
                        r_ch      <= w_start_ch;
                        r_settle  <= '0;
                        ro_en     <= w_onehot_start;
                        busy      <= 1'b1;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
                        r_timer   <= '0;
                        r_win_idx <= '0;
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                        r_state   <= S_MEASURE;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (w_win_end) begin
                        r_timer <= '0;
                        if (w_last_win) begin
                            res_data  <= CNT_W'(w_acc_sum >> r_avg);
                            res_sat   <= r_acc_sat | w_sat_nxt;
                            res_ch    <= r_ch;
                            res_valid <= 1'b1;
                            r_state   <= S_OUTPUT;
                        end else begin
                            r_acc     <= w_acc_sum;
                            r_acc_sat <= r_acc_sat | w_sat_nxt;
                            r_win_idx <= r_win_idx + WIDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + WIN_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (w_wrap && !r_cont) begin
                            ro_en   <= '0;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ch     <= w_next_ch;
                            ro_en    <= w_onehot_next;
                            r_settle <= '0;
                            r_state  <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    ro_en   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_scan_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_scan_meter
// Description : Directed self-checking bench for ro_scan_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_scan_meter;

    logic        clk = 1'b0;
    logic        rst, en, start, cont, res_ready;
    logic [3:0]  ch_mask;
    logic [15:0] win_len;
    logic [2:0]  avg_log2;
    logic [3:0]  ro_in;
    logic        ro0 = 1'b0, ro2 = 1'b0, ro3 = 1'b0;
    int          half0 = 0, half2 = 0, half3 = 0;

    logic [3:0]  ro_en, sat_ro_en;
    logic        busy, res_valid, res_sat, sat_busy, sat_res_valid, sat_res_sat;
    logic [1:0]  res_ch, sat_res_ch;
    logic [15:0] res_data;
    logic [3:0]  sat_res_data;

    int n_pass  = 0;
    int n_total = 0;

    assign ro_in = {ro3, ro2, 1'b0, ro0};

    always #5 clk = ~clk;

    ro_scan_meter u_dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .ch_mask(ch_mask),
        .win_len(win_len), .avg_log2(avg_log2), .ro_in(ro_in), .ro_en(ro_en), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_data(res_data),
        .res_sat(res_sat)
    );

    ro_scan_meter #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en), .start(start), .cont(cont), .ch_mask(ch_mask),
        .win_len(win_len), .avg_log2(avg_log2), .ro_in(ro_in), .ro_en(sat_ro_en), .busy(sat_busy),
        .res_valid(sat_res_valid), .res_ready(res_ready), .res_ch(sat_res_ch),
        .res_data(sat_res_data), .res_sat(sat_res_sat)
    );

    // Oscillator toggles land 2 or 7 time units past a multiple of 10, never on a clock edge.
    initial begin
        #2;
        forever begin
            if (half0 == 0) begin ro0 = 1'b0; #5; end
            else begin #(half0); ro0 = ~ro0; end
        end
    end
    initial begin
        #2;
        forever begin
            if (half2 == 0) begin ro2 = 1'b0; #5; end
            else begin #(half2); ro2 = ~ro2; end
        end
    end
    initial begin
        #2;
        forever begin
            if (half3 == 0) begin ro3 = 1'b0; #5; end
            else begin #(half3); ro3 = ~ro3; end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs,
                               input int lo, input int hi);
        n_total++;
        assert ((int'(obs) >= lo) && (int'(obs) <= hi)) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    initial begin
        int          cyc;
        logic        stable;
        logic [15:0] d0;

        rst = 1'b1; en = 1'b0; start = 1'b0; cont = 1'b0; res_ready = 1'b0;
        ch_mask = 4'b0000; win_len = 16'd0; avg_log2 = 3'd0;
        repeat (3) tick();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ro_en",     32'(ro_en),     32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_ch",    32'(res_ch),    32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_sat",   32'(res_sat),   32'd0);
        rst = 1'b0; en = 1'b1;
        tick();

        // Two-channel single pass; inputs changed after start must not matter.
        half0 = 50; half2 = 20;
        ch_mask = 4'b0101; win_len = 16'd100; avg_log2 = 3'd0; cont = 1'b0;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t1_busy",  32'(busy),  32'd1);
        check("t1_ro_en", 32'(ro_en), 32'b0001);
        ch_mask = 4'b1111; win_len = 16'd5; avg_log2 = 3'd3;
        wait_valid("t1_r0_valid", 300, cyc);
        check("t1_r0_ch", 32'(res_ch), 32'd0);
        check_range("t1_r0_data", 32'(res_data), 9, 11);
        check("t1_r0_sat", 32'(res_sat), 32'd0);
        d0 = res_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            if (!(res_valid === 1'b1 && res_data === d0 && res_ch === 2'd0 && ro_en === 4'b0001))
                stable = 1'b0;
        end
        start = 1'b0;
        check("t1_hold_stable", 32'(stable), 32'd1);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("t1_hs_valid_drop", 32'(res_valid), 32'd0);
        check("t1_next_ro_en",    32'(ro_en),     32'b0100);
        wait_valid("t1_r1_valid", 300, cyc);
        check("t1_r1_ch", 32'(res_ch), 32'd2);
        check_range("t1_r1_data", 32'(res_data), 24, 26);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("t1_end_busy",  32'(busy),  32'd0);
        check("t1_end_ro_en", 32'(ro_en), 32'd0);

        // Four averaged windows, exact result latency, one result only.
        half0 = 25; half2 = 0;
        ch_mask = 4'b0001; win_len = 16'd50; avg_log2 = 3'd2;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("t2_valid", 400, cyc);
        check("t2_latency", 32'(cyc + 1), 32'd209);
        check_range("t2_data", 32'(res_data), 9, 11);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        stable = 1'b1;
        repeat (30) begin
            tick();
            if (res_valid !== 1'b0) stable = 1'b0;
        end
        check("t2_single_result", 32'(stable), 32'd1);
        check("t2_idle_busy",     32'(busy),   32'd0);

        // Fast oscillator: 4-bit instance saturates, 16-bit instance does not.
        half0 = 10; win_len = 16'd100; avg_log2 = 3'd0;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t3_sat_ro_en", 32'(sat_ro_en), 32'b0001);
        wait_valid("t3_valid", 300, cyc);
        check("t3_sat_valid", 32'(sat_res_valid), 32'd1);
        check("t3_sat_data",  32'(sat_res_data),  32'd15);
        check("t3_sat_flag",  32'(sat_res_sat),   32'd1);
        check("t3_sat_ch",    32'(sat_res_ch),    32'd0);
        check("t3_wide_sat",  32'(res_sat),       32'd0);
        check_range("t3_wide_data", 32'(res_data), 49, 51);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("t3_sat_busy", 32'(sat_busy), 32'd0);

        // Abort by en mid-MEASURE, then start with an empty mask.
        half0 = 50;
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        check("t4_busy_before", 32'(busy), 32'd1);
        en = 1'b0; tick();
        check("t4_abort_busy",  32'(busy),      32'd0);
        check("t4_abort_ro_en", 32'(ro_en),     32'd0);
        check("t4_abort_valid", 32'(res_valid), 32'd0);
        en = 1'b1; ch_mask = 4'b0000;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t4_empty_busy",  32'(busy),  32'd0);
        check("t4_empty_ro_en", 32'(ro_en), 32'd0);

        // Continuous scan on a single channel, then reset mid-scan.
        half0 = 0; half3 = 20;
        ch_mask = 4'b1000; cont = 1'b1; win_len = 16'd100; avg_log2 = 3'd0;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid("t5_r0_valid", 300, cyc);
        check("t5_r0_ch", 32'(res_ch), 32'd3);
        check_range("t5_r0_data", 32'(res_data), 24, 26);
        res_ready = 1'b1;
        tick();
        cyc = 1;
        check("t5_resettle_ro_en", 32'(ro_en),     32'b1000);
        check("t5_resettle_valid", 32'(res_valid), 32'd0);
        while (res_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        res_ready = 1'b0;
        check("t5_repeat_latency", 32'(cyc), 32'd109);
        check("t5_r1_ch", 32'(res_ch), 32'd3);
        check_range("t5_r1_data", 32'(res_data), 24, 26);
        repeat (30) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_ro_en", 32'(ro_en),     32'd0);
        check("t5_rst_valid", 32'(res_valid), 32'd0);
        check("t5_rst_ch",    32'(res_ch),    32'd0);
        check("t5_rst_data",  32'(res_data),  32'd0);
        check("t5_rst_sat",   32'(res_sat),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
